// File: rtl/seq_det_pkg.sv
// Shared definitions for the "110" Moore sequence detector: state encoding
// and the overlapping next-state function.
package seq_det_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S11  = 2'd2,
        S110 = 2'd3
    } det_state_t;

    function automatic det_state_t det_next(input det_state_t s, input logic b);
        det_state_t n;
        n = S0;
        case (s)
            S0:      n = b ? S1  : S0;
            S1:      n = b ? S11 : S0;
            S11:     n = b ? S11 : S110;
            S110:    n = b ? S1  : S0;
            default: n = S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest requester at or above the pointer wins (with
// wrap); the pointer moves to one past the winner.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    int unsigned      cand;

    // Wrap by compare-and-subtract so non power-of-two N never aliases.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        if (rst && en) begin
            for (int unsigned i = 0; i < N; i++) begin
                cand = 32'(ptr) + i;
                if (cand >= N) begin
                    cand = cand - N;
                end
                if (!gnt_any && req[cand[IDX_W-1:0]]) begin
                    gnt_any                 = 1'b1;
                    gnt[cand[IDX_W-1:0]]    = 1'b1;
                    gnt_idx                 = cand[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        if (gnt_any) begin
            ptr_nxt = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// One shared "110" detector time-multiplexed over NCH serial channels, with
// per-channel saved state, saturating match counters and a tagged match pulse.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   req,
    input  logic [NCH-1:0]   bit_in,
    input  logic [NCH-1:0]   ch_clr,
    output logic [NCH-1:0]   gnt,
    output logic             match_valid,
    output logic [CH_W-1:0]  match_ch,
    input  logic [CH_W-1:0]  rd_sel,
    output logic [CNT_W-1:0] rd_cnt
);

    det_state_t       st  [NCH];
    logic [CNT_W-1:0] cnt [NCH];

    logic [NCH-1:0]   elig;
    logic [CH_W-1:0]  gidx;
    logic             gany;
    det_state_t       adv;
    logic             hit;

    // A channel being cleared is withheld from arbitration so its bit stays pending.
    assign elig = req & ~ch_clr;

    rr_arbiter #(
        .N     (NCH),
        .IDX_W (CH_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (elig),
        .gnt     (gnt),
        .gnt_idx (gidx),
        .gnt_any (gany)
    );

    always_comb begin
        adv = det_next(st[gidx], bit_in[gidx]);
        hit = gany && (adv == S110);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                st[k]  <= S0;
                cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (ch_clr[k]) begin
                    st[k]  <= S0;
                    cnt[k] <= '0;
                end else if (gnt[k]) begin
                    st[k] <= adv;
                    if (adv == S110 && cnt[k] != '1) begin
                        cnt[k] <= cnt[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_valid <= 1'b0;
            match_ch    <= '0;
        end else begin
            match_valid <= hit;
            if (hit) begin
                match_ch <= gidx;
            end
        end
    end

    always_comb begin
        rd_cnt = '0;
        if (32'(rd_sel) < NCH) begin
            rd_cnt = cnt[rd_sel];
        end
    end

endmodule
